// File: rtl/register_bank_16x32.sv
// Sixteen-entry architectural register file with one write port and R15 doubling
// as the program counter (auto-increment with a registered wrap flag).
module register_bank_16x32 #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      PC_STEP  = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter bit               R0_ZERO  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [WIDTH-1:0] Q8,
  output logic [WIDTH-1:0] Q9,
  output logic [WIDTH-1:0] Q10,
  output logic [WIDTH-1:0] Q11,
  output logic [WIDTH-1:0] Q12,
  output logic [WIDTH-1:0] Q13,
  output logic [WIDTH-1:0] Q14,
  output logic [WIDTH-1:0] Q15,
  output logic             pc_wrap
);

  logic [WIDTH-1:0]      regs_r [16];
  logic                  pc_wrap_r;
  logic [15:0]           we_s;
  logic                  pc_inc_s;
  logic [WIDTH:0]        pc_sum_s;
  logic [16*WIDTH-1:0]   flat_s;

  // Per-register write enable decode; an unknown wr_sel yields no asserted enable.
  always_comb begin
    we_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      we_s[i] = wr_en & (wr_sel == 4'(i));
    end
    if (R0_ZERO) begin
      we_s[0] = 1'b0;
    end else begin
      we_s[0] = we_s[0];
    end
  end

  // PC increment path; an explicit write to R15 takes precedence (branch/jump).
  always_comb begin
    pc_inc_s = pc_inc & ~we_s[15];
    pc_sum_s = {1'b0, regs_r[15]} + (WIDTH+1)'(PC_STEP);
  end

  // Register array, PC update and wrap flag; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= '0;
      end
      regs_r[15] <= RESET_PC;
      pc_wrap_r  <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (we_s[i]) begin
          regs_r[i] <= wr_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      if (we_s[15]) begin
        regs_r[15] <= wr_data;
      end else if (pc_inc_s) begin
        regs_r[15] <= pc_sum_s[WIDTH-1:0];
      end else begin
        regs_r[15] <= regs_r[15];
      end
      pc_wrap_r <= pc_inc_s & pc_sum_s[WIDTH];
    end
  end

  // Flattened view of the array for the protocol checker.
  always_comb begin
    flat_s = '0;
    for (int i = 0; i < 16; i++) begin
      flat_s[i*WIDTH +: WIDTH] = regs_r[i];
    end
  end

  assign Q0      = R0_ZERO ? '0 : regs_r[0];
  assign Q1      = regs_r[1];
  assign Q2      = regs_r[2];
  assign Q3      = regs_r[3];
  assign Q4      = regs_r[4];
  assign Q5      = regs_r[5];
  assign Q6      = regs_r[6];
  assign Q7      = regs_r[7];
  assign Q8      = regs_r[8];
  assign Q9      = regs_r[9];
  assign Q10     = regs_r[10];
  assign Q11     = regs_r[11];
  assign Q12     = regs_r[12];
  assign Q13     = regs_r[13];
  assign Q14     = regs_r[14];
  assign Q15     = regs_r[15];
  assign pc_wrap = pc_wrap_r;

  register_bank_16x32_chk #(.WIDTH(WIDTH)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_sel (wr_sel),
    .pc_inc (pc_inc),
    .state  (flat_s)
  );

endmodule

// Simulation-only check: a write with an unknown destination must leave every register untouched.
module register_bank_16x32_chk #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  input logic                wr_en,
  input logic [3:0]          wr_sel,
  input logic                pc_inc,
  input logic [16*WIDTH-1:0] state
);

  // Unknown write index must not disturb the array.
  a_xsel_no_update : assert property (
    @(posedge clk) (!rst && wr_en && $isunknown(wr_sel) && !pc_inc) |=> (rst || $stable(state))
  );

endmodule

// File: tb/tb_register_bank_16x32.sv
// Randomized scoreboard bench: two DUTs (R0 writable / R0 hardwired) share stimulus;
// a reference model pushes expected state, a monitor pops and compares after each edge.
module tb_register_bank_16x32;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, wr_en, pc_inc;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic [31:0] qa [16];
  logic [31:0] qz [16];
  logic        wrap_a, wrap_z;

  typedef struct packed {
    logic [15:0][31:0] q;
    logic [15:0][31:0] qz;
    logic              wrap;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic        have_exp = 1'b0;
  logic [31:0] m  [16];
  logic [31:0] mz [16];
  logic        mwrap;
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  register_bank_16x32 #(.WIDTH(32), .PC_STEP(1), .RESET_PC(RPC), .R0_ZERO(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pc_inc(pc_inc),
    .Q0(qa[0]), .Q1(qa[1]), .Q2(qa[2]), .Q3(qa[3]), .Q4(qa[4]), .Q5(qa[5]), .Q6(qa[6]), .Q7(qa[7]),
    .Q8(qa[8]), .Q9(qa[9]), .Q10(qa[10]), .Q11(qa[11]), .Q12(qa[12]), .Q13(qa[13]), .Q14(qa[14]),
    .Q15(qa[15]), .pc_wrap(wrap_a)
  );

  register_bank_16x32 #(.WIDTH(32), .PC_STEP(1), .RESET_PC(RPC), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pc_inc(pc_inc),
    .Q0(qz[0]), .Q1(qz[1]), .Q2(qz[2]), .Q3(qz[3]), .Q4(qz[4]), .Q5(qz[5]), .Q6(qz[6]), .Q7(qz[7]),
    .Q8(qz[8]), .Q9(qz[9]), .Q10(qz[10]), .Q11(qz[11]), .Q12(qz[12]), .Q13(qz[13]), .Q14(qz[14]),
    .Q15(qz[15]), .pc_wrap(wrap_z)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, req);
    end
  endtask

  task automatic cmp_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_q"}, i, qa[i], cur.q[i]);
      check({tag, "_qz"}, i, qz[i], cur.qz[i]);
    end
    check({tag, "_wrap"}, 0, {31'd0, wrap_a}, {31'd0, cur.wrap});
    check({tag, "_wrapz"}, 0, {31'd0, wrap_z}, {31'd0, cur.wrap});
  endtask

  // Apply one cycle of stimulus and record the architectural state expected after the edge.
  task automatic drive(input logic r, input logic we, input logic [3:0] s, input logic [31:0] d,
                       input logic inc);
    logic [32:0] sum;
    exp_t        e;
    @(negedge clk);
    rst = r; wr_en = we; wr_sel = s; wr_data = d; pc_inc = inc;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m[i]  = 32'd0;
        mz[i] = 32'd0;
      end
      m[15]  = RPC;
      mz[15] = RPC;
      mwrap  = 1'b0;
    end else begin
      mwrap = 1'b0;
      if (we && s == 4'd15) begin
        m[15]  = d;
        mz[15] = d;
      end else if (inc) begin
        sum    = 33'(m[15]) + 33'd1;
        mwrap  = (sum >= 33'h1_0000_0000);
        m[15]  = sum[31:0];
        mz[15] = sum[31:0];
      end
      if (we && s != 4'd15) begin
        m[s] = d;
        if (s != 4'd0) mz[s] = d;
      end
    end
    for (int i = 0; i < 16; i++) begin
      e.q[i]  = m[i];
      e.qz[i] = mz[i];
    end
    e.wrap = mwrap;
    sbq.push_back(e);
  endtask

  // Monitor: compare right after each edge, then again mid-cycle after new inputs are applied.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        cur      = sbq.pop_front();
        have_exp = 1'b1;
        cmp_all("post");
      end
      @(negedge clk);
      #2;
      if (have_exp) cmp_all("hold");
    end
  end

  initial begin
    logic        r_v, we_v, inc_v;
    logic [3:0]  s_v;
    logic [31:0] d_v;
    rst = 1'b0; wr_en = 1'b0; wr_sel = 4'd0; wr_data = 32'd0; pc_inc = 1'b0;

    drive(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 1'b1, 4'd7, 32'h1234_5678, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), 32'(i) * 32'h0101_0101, 1'b0);
    end
    drive(1'b0, 1'b1, 4'd15, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 1'b1, 4'd15, 32'h0000_0040, 1'b1);
    drive(1'b0, 1'b1, 4'd2, 32'h0000_0055, 1'b1);
    drive(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 1'b1, 4'd5, 32'hA5A5_A5A5, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r_v   = ($urandom_range(0, 31) == 0);
      we_v  = 1'($urandom_range(0, 1));
      s_v   = 4'($urandom_range(0, 15));
      d_v   = $urandom;
      inc_v = 1'($urandom_range(0, 1));
      if (s_v == 4'd15 && $urandom_range(0, 1) == 1) d_v = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      drive(r_v, we_v, s_v, d_v, inc_v);
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
